// File: rtl/dii_packetizer_if.sv
// DII flit channel: one flit per valid & ready, last marks the final flit of a packet.
interface dii_channel #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             last;
    logic             valid;
    logic             ready;

    modport source (output data, output last, output valid, input ready);
    modport sink   (input data, input last, input valid, output ready);
endinterface

// File: rtl/dii_packetizer.sv
// Builds one DII packet (dest, src, flags, payload) from a parallel request and
// serialises it flit-by-flit onto a dii_channel; one packet in flight at a time.
module dii_packetizer #(
    parameter int  WIDTH       = 16,
    parameter int  MAX_PAYLOAD = 8,
    localparam int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [WIDTH-1:0]             req_dest,
    input  logic [WIDTH-1:0]             req_src,
    input  logic [1:0]                   req_type,
    input  logic [3:0]                   req_type_sub,
    input  logic [LEN_W-1:0]             req_len,
    input  logic [MAX_PAYLOAD*WIDTH-1:0] req_payload,
    output logic                         busy,
    dii_channel.source                   out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DEST    = 3'd1;
    localparam logic [2:0] S_SRC     = 3'd2;
    localparam logic [2:0] S_FLAGS   = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] dest_q, dest_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [1:0]       type_q, type_d;
    logic [3:0]       sub_q, sub_d;
    logic [WIDTH-1:0] pay_q [MAX_PAYLOAD];
    logic [WIDTH-1:0] pay_d [MAX_PAYLOAD];

    logic             accept;
    logic             valid;
    logic             xfer;
    logic             final_word;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data;
    logic             last;

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = !req_ready;
    assign valid      = (state_q != S_IDLE);
    assign accept     = req_valid && req_ready;
    assign xfer       = valid && out.ready;
    assign final_word = (cnt_q + LEN_W'(1)) == len_q;

    // Constant-index compare loop keeps the word select free of index-width truncation.
    always_comb begin
        word = '0;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (cnt_q == LEN_W'(k)) word = pay_q[k];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dest_d  = dest_q;
        src_d   = src_q;
        type_d  = type_q;
        sub_d   = sub_q;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            pay_d[k] = accept ? req_payload[k*WIDTH +: WIDTH] : pay_q[k];
        end

        if (accept) begin
            state_d = S_DEST;
            cnt_d   = '0;
            len_d   = (req_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : req_len;
            dest_d  = req_dest;
            src_d   = req_src;
            type_d  = req_type;
            sub_d   = req_type_sub;
        end else if (xfer) begin
            case (state_q)
                S_DEST:  state_d = S_SRC;
                S_SRC:   state_d = S_FLAGS;
                S_FLAGS: begin
                    state_d = (len_q == '0) ? S_IDLE : S_PAYLOAD;
                    cnt_d   = '0;
                end
                S_PAYLOAD: begin
                    if (final_word) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        data = '0;
        last = 1'b0;
        case (state_q)
            S_DEST:    data = dest_q;
            S_SRC:     data = src_q;
            S_FLAGS: begin
                data = WIDTH'({type_q, sub_q, 10'b0});
                last = (len_q == '0);
            end
            S_PAYLOAD: begin
                data = word;
                last = final_word;
            end
            default:   data = '0;
        endcase
    end

    assign out.valid = valid;
    assign out.data  = data;
    assign out.last  = last;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the request copy is not reset; it is only observed outside IDLE, after a capture.
    always_ff @(posedge clk) begin
        len_q  <= len_d;
        dest_q <= dest_d;
        src_q  <= src_d;
        type_q <= type_d;
        sub_q  <= sub_d;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            pay_q[k] <= pay_d[k];
        end
    end

endmodule
